// File: rtl/lru_age_tracker.sv
// lru_age_tracker: true-LRU replacement state for one cache set.
// Each way holds a unique age (0 = most recently used, NUM_WAYS-1 = least
// recently used) and a valid bit. Access/fill moves a way to the MRU end.
// Invalidate moves it to the LRU end. The ages stay a permutation at all
// times. A victim is offered every cycle: invalid unlocked ways are chosen
// first, and otherwise the oldest unlocked valid way is chosen.
module lru_age_tracker #(
  parameter int NUM_WAYS = 4,
  parameter int IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                access_v_i,
  input  logic [IDX_W-1:0]    access_idx_i,
  input  logic                access_fill_i,
  input  logic                inval_v_i,
  input  logic [IDX_W-1:0]    inval_idx_i,
  input  logic [NUM_WAYS-1:0] lock_mask_i,
  output logic [IDX_W-1:0]    victim_idx_o,
  output logic                victim_v_o,
  output logic                all_valid_o
);

  localparam logic [IDX_W-1:0] OLDEST = IDX_W'(NUM_WAYS - 1);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

  logic [NUM_WAYS-1:0][IDX_W-1:0] age;
  logic [NUM_WAYS-1:0]            valid;

  logic [IDX_W-1:0] access_age;
  logic [IDX_W-1:0] inval_age;

  logic             inv_found;
  logic [IDX_W-1:0] inv_idx;
  logic             old_found;
  logic [IDX_W-1:0] old_idx;
  logic [IDX_W-1:0] old_age;

  assign access_age = age[access_idx_i];
  assign inval_age  = age[inval_idx_i];

  // Age/valid update. Reset wins over invalidate, and invalidate wins over a
  // same-cycle access, which is then dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        age[i] <= IDX_W'(i);
      end
      valid <= '0;
    end else if (inval_v_i) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (IDX_W'(i) == inval_idx_i) begin
          age[i] <= OLDEST;
        end else if (age[i] > inval_age) begin
          age[i] <= age[i] - ONE;
        end
      end
      valid[inval_idx_i] <= 1'b0;
    end else if (access_v_i) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (IDX_W'(i) == access_idx_i) begin
          age[i] <= '0;
        end else if (age[i] < access_age) begin
          age[i] <= age[i] + ONE;
        end
      end
      if (access_fill_i) begin
        valid[access_idx_i] <= 1'b1;
      end
    end
  end

  // Victim search: lowest-index invalid unlocked way, else oldest unlocked valid way.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    old_found = 1'b0;
    old_idx   = '0;
    old_age   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!valid[i] && !lock_mask_i[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (valid[i] && !lock_mask_i[i] && (!old_found || age[i] > old_age)) begin
        old_found = 1'b1;
        old_idx   = IDX_W'(i);
        old_age   = age[i];
      end
    end
  end

  assign victim_v_o   = inv_found | old_found;
  assign victim_idx_o = inv_found ? inv_idx : (old_found ? old_idx : '0);
  assign all_valid_o  = &valid;

endmodule

// File: tb/tb_lru_age_tracker.sv
// tb_lru_age_tracker: scoreboard bench for lru_age_tracker.
// A 4-way instance runs the directed scenarios and an 8-way instance runs
// the randomised event stream. The reference model keeps an MRU-to-LRU
// ordered list of ways, so a way's age is its position in that list.
module tb_lru_age_tracker;

  typedef struct packed {
    logic [2:0]      vidx;
    logic            vv;
    logic            allv;
    logic [7:0][2:0] ages;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a4_v, a4_fill, i4_v;
  logic [1:0] a4_idx, i4_idx;
  logic [3:0] lock4;
  logic [1:0] victim4;
  logic       vv4, av4;

  logic       a8_v, a8_fill, i8_v;
  logic [2:0] a8_idx, i8_idx;
  logic [7:0] lock8;
  logic [2:0] victim8;
  logic       vv8, av8;

  int   checks = 0;
  int   errors = 0;
  int   order[$];
  bit   [7:0] mvalid;
  exp_t sb[$];

  always #5 clk = ~clk;

  lru_age_tracker #(.NUM_WAYS(4)) dut4 (
    .clk(clk), .rst(rst),
    .access_v_i(a4_v), .access_idx_i(a4_idx), .access_fill_i(a4_fill),
    .inval_v_i(i4_v), .inval_idx_i(i4_idx), .lock_mask_i(lock4),
    .victim_idx_o(victim4), .victim_v_o(vv4), .all_valid_o(av4)
  );

  lru_age_tracker #(.NUM_WAYS(8)) dut8 (
    .clk(clk), .rst(rst),
    .access_v_i(a8_v), .access_idx_i(a8_idx), .access_fill_i(a8_fill),
    .inval_v_i(i8_v), .inval_idx_i(i8_idx), .lock_mask_i(lock8),
    .victim_idx_o(victim8), .victim_v_o(vv8), .all_valid_o(av8)
  );

  function automatic void model_reset(int n);
    order.delete();
    for (int i = 0; i < n; i++) order.push_back(i);
    mvalid = '0;
  endfunction

  function automatic void move_way(int w, bit to_front);
    int pos = 0;
    for (int p = 0; p < order.size(); p++) if (order[p] == w) pos = p;
    order.delete(pos);
    if (to_front) order.push_front(w);
    else order.push_back(w);
  endfunction

  function automatic void model_step(bit av, int aidx, bit fill, bit iv, int iidx);
    if (iv) begin
      move_way(iidx, 1'b0);
      mvalid[iidx] = 1'b0;
    end else if (av) begin
      move_way(aidx, 1'b1);
      if (fill) mvalid[aidx] = 1'b1;
    end
  endfunction

  function automatic exp_t model_expect(int n, logic [7:0] lock);
    exp_t e;
    bit   done;
    e = '0;
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!done && !mvalid[i] && !lock[i]) begin
        e.vidx = 3'(i);
        e.vv   = 1'b1;
        done   = 1'b1;
      end
    end
    for (int p = n - 1; p >= 0; p--) begin
      if (!done && mvalid[order[p]] && !lock[order[p]]) begin
        e.vidx = 3'(order[p]);
        e.vv   = 1'b1;
        done   = 1'b1;
      end
    end
    e.allv = 1'b1;
    for (int i = 0; i < n; i++) if (!mvalid[i]) e.allv = 1'b0;
    for (int p = 0; p < n; p++) e.ages[order[p]] = 3'(p);
    return e;
  endfunction

  function automatic logic [7:0][2:0] obs4();
    logic [7:0][2:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i] = {1'b0, dut4.age[i]};
    return r;
  endfunction

  function automatic logic [7:0][2:0] obs8();
    logic [7:0][2:0] r;
    for (int i = 0; i < 8; i++) r[i] = dut8.age[i];
    return r;
  endfunction

  function automatic logic [7:0][2:0] ages4(int a0, int a1, int a2, int a3);
    logic [7:0][2:0] r;
    r = '0;
    r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3);
    return r;
  endfunction

  task automatic applyStimulus(input bit av, input int aidx, input bit fill,
                               input bit iv, input int iidx, input logic [3:0] lock);
    a4_v = av; a4_idx = 2'(aidx); a4_fill = fill;
    i4_v = iv; i4_idx = 2'(iidx); lock4 = lock;
    model_step(av, aidx, fill, iv, iidx);
    sb.push_back(model_expect(4, {4'b0, lock}));
    @(posedge clk); #1;
    a4_v = 1'b0; i4_v = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(4);
    sb.delete();
  endtask

  task automatic setup_full();
    pulse_reset();
    for (int w = 0; w < 4; w++) applyStimulus(1'b1, w, 1'b1, 1'b0, 0, 4'b0);
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; a4_v = 1'b1; a4_idx = 2'd3; a4_fill = 1'b1; i4_v = 1'b0; lock4 = 4'b0;
    @(posedge clk); #1;
    rst = 1'b0; a4_v = 1'b0;
    model_reset(4);
    sb.push_back(model_expect(4, 8'h00));
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got idx=%0d v=%0d all=%0d, expected idx=%0d v=%0d all=%0d",
               victim4, vv4, av4, e.vidx, e.vv, e.allv);
    end
    checks++;
    if (obs4() !== ages4(0, 1, 2, 3) || {victim4, vv4, av4} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_state: got ages=%h idx=%0d v=%0d all=%0d, expected ages=%h idx=0 v=1 all=0",
               obs4(), victim4, vv4, av4, ages4(0, 1, 2, 3));
    end
  endtask

  task automatic test_fill();
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      applyStimulus(1'b1, w, 1'b1, 1'b0, 0, 4'b0);
      e = sb.pop_front();
      checks++;
      if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv} || obs4() !== e.ages) begin
        errors++;
        $display("[TB] FAIL fill_way%0d: got idx=%0d v=%0d all=%0d ages=%h, expected idx=%0d v=%0d all=%0d ages=%h",
                 w, victim4, vv4, av4, obs4(), e.vidx, e.vv, e.allv, e.ages);
      end
    end
    checks++;
    if (obs4() !== ages4(3, 2, 1, 0) || av4 !== 1'b1 || victim4 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL fill_final: got ages=%h all=%0d idx=%0d, expected ages=%h all=1 idx=0",
               obs4(), av4, victim4, ages4(3, 2, 1, 0));
    end
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 4'b0);
    e = sb.pop_front();
    checks++;
    if (obs4() !== e.ages || obs4() !== ages4(0, 3, 2, 1) || victim4 !== 2'd1 || victim4 !== e.vidx[1:0]) begin
      errors++;
      $display("[TB] FAIL hit_way0: got ages=%h idx=%0d, expected ages=%h idx=1",
               obs4(), victim4, ages4(0, 3, 2, 1));
    end
  endtask

  task automatic test_invalidate();
    exp_t e;
    setup_full();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 2, 4'b0);
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv} || obs4() !== e.ages) begin
      errors++;
      $display("[TB] FAIL inval_model: got idx=%0d v=%0d all=%0d ages=%h, expected idx=%0d v=%0d all=%0d ages=%h",
               victim4, vv4, av4, obs4(), e.vidx, e.vv, e.allv, e.ages);
    end
    checks++;
    if (obs4() !== ages4(2, 1, 3, 0) || victim4 !== 2'd2 || av4 !== 1'b0 || dut4.valid[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inval_way2: got ages=%h idx=%0d all=%0d, expected ages=%h idx=2 all=0",
               obs4(), victim4, av4, ages4(2, 1, 3, 0));
    end
    lock4 = 4'b0100; #1;
    sb.push_back(model_expect(4, 8'h04));
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4} !== {e.vidx[1:0], e.vv} || victim4 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL inval_locked: got idx=%0d v=%0d, expected idx=%0d v=%0d",
               victim4, vv4, e.vidx, e.vv);
    end
    lock4 = 4'b0;
  endtask

  task automatic test_lock();
    exp_t e;
    setup_full();
    lock4 = 4'b0011; #1;
    sb.push_back(model_expect(4, 8'h03));
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4} !== {e.vidx[1:0], e.vv} || victim4 !== 2'd2) begin
      errors++;
      $display("[TB] FAIL lock_0011: got idx=%0d v=%0d, expected idx=2 v=1", victim4, vv4);
    end
    lock4 = 4'b1111; #1;
    sb.push_back(model_expect(4, 8'h0F));
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv} || {victim4, vv4} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL lock_all: got idx=%0d v=%0d all=%0d, expected idx=0 v=0 all=1",
               victim4, vv4, av4);
    end
    lock4 = 4'b0;
  endtask

  task automatic test_collision();
    exp_t e;
    setup_full();
    applyStimulus(1'b1, 3, 1'b1, 1'b1, 1, 4'b0);
    e = sb.pop_front();
    checks++;
    if (obs4() !== e.ages || obs4() !== ages4(2, 3, 1, 0) || dut4.valid[3] !== 1'b1 || dut4.valid[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision: got ages=%h valid=%b, expected ages=%h valid=1101",
               obs4(), dut4.valid, ages4(2, 3, 1, 0));
    end
    checks++;
    if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv}) begin
      errors++;
      $display("[TB] FAIL collision_out: got idx=%0d v=%0d all=%0d, expected idx=%0d v=%0d all=%0d",
               victim4, vv4, av4, e.vidx, e.vv, e.allv);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   ev[7][5];
    ev = '{'{1, 2, 0, 0, 0}, '{1, 2, 0, 0, 0}, '{1, 1, 0, 0, 0}, '{0, 0, 0, 1, 0},
           '{1, 3, 0, 0, 0}, '{1, 0, 1, 0, 0}, '{0, 0, 0, 1, 0}};
    setup_full();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(ev[k][0] != 0, ev[k][1], ev[k][2] != 0, ev[k][3] != 0, ev[k][4], 4'b0);
      e = sb.pop_front();
      checks++;
      if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv} || obs4() !== e.ages) begin
        errors++;
        $display("[TB] FAIL b2b_step%0d: got idx=%0d v=%0d all=%0d ages=%h, expected idx=%0d v=%0d all=%0d ages=%h",
                 k, victim4, vv4, av4, obs4(), e.vidx, e.vv, e.allv, e.ages);
      end
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    setup_full();
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 0, 4'b0);
    void'(sb.pop_front());
    rst = 1'b1; a4_v = 1'b1; a4_idx = 2'd3; a4_fill = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a4_v = 1'b0;
    model_reset(4);
    sb.push_back(model_expect(4, 8'h00));
    e = sb.pop_front();
    checks++;
    if ({victim4, vv4, av4} !== {e.vidx[1:0], e.vv, e.allv} || obs4() !== ages4(0, 1, 2, 3) || dut4.valid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got idx=%0d v=%0d all=%0d ages=%h, expected idx=0 v=1 all=0 ages=%h",
               victim4, vv4, av4, obs4(), ages4(0, 1, 2, 3));
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit   r_rst, r_av, r_fill, r_iv;
    int   r_aidx, r_iidx;
    logic [7:0] r_lock;
    logic [7:0] seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(8);
    for (int n = 0; n < 10000; n++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_iv   = ($urandom_range(0, 4) == 0);
      r_av   = ($urandom_range(0, 9) < 7);
      r_fill = ($urandom_range(0, 1) == 1);
      r_aidx = $urandom_range(0, 7);
      r_iidx = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0:       r_lock = 8'($urandom);
        1:       r_lock = 8'hFF;
        default: r_lock = 8'h00;
      endcase
      rst = r_rst; a8_v = r_av; a8_idx = 3'(r_aidx); a8_fill = r_fill;
      i8_v = r_iv; i8_idx = 3'(r_iidx); lock8 = r_lock;
      if (r_rst) model_reset(8);
      else model_step(r_av, r_aidx, r_fill, r_iv, r_iidx);
      sb.push_back(model_expect(8, r_lock));
      @(posedge clk); #1;
      rst = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({victim8, vv8, av8} !== {e.vidx, e.vv, e.allv}) begin
        errors++;
        $display("[TB] FAIL rand_victim@%0d: got idx=%0d v=%0d all=%0d, expected idx=%0d v=%0d all=%0d",
                 n, victim8, vv8, av8, e.vidx, e.vv, e.allv);
      end
      checks++;
      if (obs8() !== e.ages) begin
        errors++;
        $display("[TB] FAIL rand_ages@%0d: got %h, expected %h", n, obs8(), e.ages);
      end
      seen = '0;
      for (int i = 0; i < 8; i++) seen[dut8.age[i]] = 1'b1;
      checks++;
      if (seen !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL rand_perm@%0d: ages seen=%b, expected 11111111", n, seen);
      end
    end
    a8_v = 1'b0; i8_v = 1'b0;
  endtask

  // Directed 4-way scenarios followed by the randomised 8-way stream.
  initial begin
    rst = 1'b0;
    a4_v = 1'b0; a4_idx = '0; a4_fill = 1'b0; i4_v = 1'b0; i4_idx = '0; lock4 = '0;
    a8_v = 1'b0; a8_idx = '0; a8_fill = 1'b0; i8_v = 1'b0; i8_idx = '0; lock8 = '0;
    @(posedge clk); #1;
    $display("[TB] starting lru_age_tracker bench");
    test_reset();
    test_fill();
    test_invalidate();
    test_lock();
    test_collision();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
